// File: rtl/seq_sub_pkg.sv
// Shared types and elaboration helpers for the multi-cycle half subtractor.
package seq_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CHUNK = 4;

  function automatic int half_of(input int width);
    return width / 2;
  endfunction

  function automatic int nchunk_of(input int width, input int chunk);
    return (width / 2) / chunk;
  endfunction

  // A legal configuration splits into two equal halves of whole slices.
  function automatic bit cfg_ok(input int width, input int chunk);
    return (width > 0) && (width % 2 == 0) && (chunk > 0) && ((width / 2) % chunk == 0);
  endfunction

endpackage

// File: rtl/seq_half_subtractor_sub_chunk.sv
// Combinational CHUNK-bit borrow subtractor, shared by every slice of an operation.
module sub_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             bi,
  output logic [CHUNK-1:0] d,
  output logic             bo
);

  logic [CHUNK:0] res;

  // One extra bit wide so the wrap-around lands in the MSB as the borrow.
  assign res     = {1'b0, a} - {1'b0, b} - {{CHUNK{1'b0}}, bi};
  assign {bo, d} = res;

endmodule

// File: rtl/seq_half_subtractor.sv
// Multi-cycle subtractor computing A - B - bin, CHUNK bits per cycle, valid/ready on both sides.
// Optional build macro SUB_SATURATE_EN: clamp diff to 0 when the final borrow is set.
//
// state | meaning
// IDLE  | in_ready high, waiting for an operation
// RUN   | one slice per cycle, borrow carried in borrow_q
// DONE  | out_valid high, result held until out_ready
module seq_half_subtractor
  import seq_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   data_in,
  input  logic               bin,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH/2-1:0] diff,
  output logic               bout
);

  localparam int HALF   = half_of(WIDTH);
  localparam int NCHUNK = nchunk_of(WIDTH, CHUNK);
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (!cfg_ok(WIDTH, CHUNK)) begin : g_bad_cfg
    $error("seq_half_subtractor: WIDTH must be even and CHUNK must divide WIDTH/2");
  end

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [HALF-1:0]  a_q, a_d;
  logic [HALF-1:0]  b_q, b_d;
  logic [HALF-1:0]  diff_q, diff_d;
  logic             borrow_q, borrow_d;

  logic [CHUNK-1:0] a_slice, b_slice, d_slice;
  logic             bo_slice;
  logic [HALF-1:0]  diff_shift;
  logic             last_slice;

  assign a_slice    = a_q[idx_q*CHUNK +: CHUNK];
  assign b_slice    = b_q[idx_q*CHUNK +: CHUNK];
  assign last_slice = (idx_q == IDX_W'(NCHUNK - 1));

  sub_chunk #(.CHUNK(CHUNK)) u_sub_chunk (
    .a  (a_slice),
    .b  (b_slice),
    .bi (borrow_q),
    .d  (d_slice),
    .bo (bo_slice)
  );

  // Slices enter at the top, so slice 0 ends up in the low bits after NCHUNK shifts.
  assign diff_shift = (diff_q >> CHUNK) | (HALF'(d_slice) << (HALF - CHUNK));

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d      = data_in[HALF-1:0];
          b_d      = data_in[WIDTH-1:HALF];
          borrow_d = bin;
          idx_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        diff_d   = diff_shift;
        borrow_d = bo_slice;
        idx_d    = idx_q + IDX_W'(1);
        if (last_slice) begin
          idx_d   = '0;
          state_d = DONE;
`ifdef SUB_SATURATE_EN
          if (bo_slice) diff_d = '0;
`endif
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign diff      = diff_q;
  assign bout      = borrow_q;

endmodule

// File: tb/tb_seq_half_subtractor.sv
// Scoreboard bench for seq_half_subtractor: directed cases plus randomized traffic with stalls.
module tb_seq_half_subtractor;

  localparam int WIDTH  = 32;
  localparam int CHUNK  = 4;
  localparam int HALF   = WIDTH / 2;
  localparam int NCHUNK = HALF / CHUNK;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data_in;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [HALF-1:0]  diff;
  logic             bout;

  logic rand_mode = 1'b0;
  logic ready_fix = 1'b1;
  logic rnd_ready = 1'b1;

  assign out_ready = rand_mode ? rnd_ready : ready_fix;

  seq_half_subtractor #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [HALF-1:0] d;
    logic            b;
    int              acc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_acc = 0;
  int   n_res = 0;
  int   cycle_cnt = 0;
  logic prev_ov = 1'b0;

  always @(posedge clk) begin
    cycle_cnt <= cycle_cnt + 1;
    rnd_ready <= ($urandom_range(0, 3) != 0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the whole operands.
  function automatic exp_t model(input logic [WIDTH-1:0] word, input logic bi, input int acc);
    exp_t e;
    int   a, b;
    a     = int'(word[HALF-1:0]);
    b     = int'(word[WIDTH-1:HALF]);
    e.b   = (a < b + int'(bi));
    e.d   = HALF'(a - b - int'(bi));
`ifdef SUB_SATURATE_EN
    if (e.b) e.d = '0;
`endif
    e.acc = acc;
    return e;
  endfunction

  // Monitor: accepts push expectations, output handshakes pop and compare.
  always @(negedge clk) begin
    if (rst && in_valid && in_ready) begin
      sb.push_back(model(data_in, bin, cycle_cnt + 1));
      n_acc++;
    end
    if (rst && out_valid && !prev_ov) begin
      if (sb.size() == 0) check("latency_no_expect", 32'd1, 32'd0);
      else check("latency", 32'(cycle_cnt - sb[0].acc), 32'(NCHUNK));
    end
    if (rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_diff", 32'(diff), 32'(e.d));
        check("sb_bout", 32'(bout), 32'(e.b));
      end
      n_res++;
    end
    prev_ov = out_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [WIDTH-1:0] word, input logic bi);
    int budget;
    in_valid = 1'b1;
    data_in  = word;
    bin      = bi;
    budget   = 0;
    while (!in_ready && budget < 200) begin
      tick();
      budget++;
    end
    if (!in_ready) check("send_timeout", 32'd1, 32'd0);
    tick();
    in_valid = 1'b0;
    data_in  = $urandom;
    bin      = 1'($urandom);
  endtask

  task automatic wait_valid();
    int budget;
    budget = 0;
    while (!out_valid && budget < 50) begin
      tick();
      budget++;
    end
    if (!out_valid) check("wait_valid_timeout", 32'd1, 32'd0);
  endtask

  task automatic directed(input string name, input logic [WIDTH-1:0] word, input logic bi,
                          input logic [HALF-1:0] exp_d, input logic exp_b);
    ready_fix = 1'b1;
    send(word, bi);
    wait_valid();
    check({name, "_diff"}, 32'(diff), 32'(exp_d));
    check({name, "_bout"}, 32'(bout), 32'(exp_b));
    tick();
  endtask

  initial begin
    logic [HALF-1:0] d0;
    logic            b0;
    int              budget;

    rst      = 1'b0;
    in_valid = 1'b0;
    data_in  = '0;
    bin      = 1'b0;
    repeat (3) tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
    rst = 1'b1;
    tick();

    directed("basic", 32'h0003_0005, 1'b0, 16'h0002, 1'b0);
`ifdef SUB_SATURATE_EN
    directed("underflow", 32'h0001_0000, 1'b0, 16'h0000, 1'b1);
`else
    directed("underflow", 32'h0001_0000, 1'b0, 16'hFFFF, 1'b1);
`endif
    directed("xchunk1", 32'h0001_0100, 1'b1, 16'h00FE, 1'b0);
    directed("xchunk2", 32'h0001_1000, 1'b1, 16'h0FFE, 1'b0);

    // Backpressure: hold the result while a competing word is offered.
    ready_fix = 1'b0;
    send(32'h1234_5678, 1'b1);
    wait_valid();
    d0 = diff;
    b0 = bout;
    check("bp_diff_value", 32'(d0), 32'h0000_4443);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      data_in  = $urandom;
      bin      = 1'($urandom);
      tick();
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_diff_hold", 32'(diff), 32'(d0));
      check("bp_bout_hold", 32'(bout), 32'(b0));
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    ready_fix = 1'b1;
    tick();
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_release_out_valid", 32'(out_valid), 32'd0);
    directed("after_bp", 32'h00FF_0100, 1'b0, 16'h0001, 1'b0);

    // Reset during RUN discards the in-flight operation.
    send(32'hAAAA_5555, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    check("midrun_out_valid", 32'(out_valid), 32'd0);
    check("midrun_diff", 32'(diff), 32'd0);
    check("midrun_bout", 32'(bout), 32'd0);
    check("midrun_in_ready", 32'(in_ready), 32'd1);
    sb.delete();
    n_acc--;
    rst = 1'b1;
    tick();
    directed("after_rst", 32'h0010_0020, 1'b1, 16'h000F, 1'b0);

    // Randomized back-to-back traffic with consumer stalls.
    rand_mode = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      send({16'($urandom), 16'($urandom)}, 1'($urandom));
    end
    budget = 0;
    while ((sb.size() != 0 || out_valid) && budget < 500) begin
      tick();
      budget++;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
    check("result_count", 32'(n_res), 32'(n_acc));
    rand_mode = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_half_subtractor.md
# seq_half_subtractor

Multi-cycle subtractor, the inverse-direction companion of the team's registered full adder. Takes one packed WIDTH-bit word (minuend in the low half, subtrahend in the high half) plus a borrow-in, and computes `minuend - subtrahend - bin` over several cycles, CHUNK bits per cycle, propagating a registered borrow between slices. Sits in the same datapath test harness as the adder and uses a valid/ready handshake on both sides.

## Interface
- WIDTH, 32, packed input width; must be even. HALF = WIDTH/2 is the operand width.
- CHUNK, 4, bits processed per cycle; must divide HALF. NCHUNK = HALF/CHUNK.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- in_valid  in  1  input word and bin are valid.
- in_ready  out  1  block can accept an operation.
- data_in  in  WIDTH  [HALF-1:0] is the minuend A; [WIDTH-1:HALF] is the subtrahend B.
- bin  in  1  borrow-in, sampled with data_in.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- diff  out  HALF  A - B - bin, modulo 2^HALF (see Configuration).
- bout  out  1  final borrow-out; 1 when A < B + bin.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid && in_ready: latch A, B, bin into the borrow register; clear chunk index; go to RUN.
- RUN: each cycle, subtract slice idx of A and B with the current borrow. Write the CHUNK-bit result into the diff shift register and the new borrow into the borrow register. Increment idx. After slice NCHUNK-1, go to DONE.
- DONE: out_valid=1; diff and bout are stable. On out_ready: go to IDLE.
- in_valid is ignored outside IDLE. Inputs change freely after acceptance.
- Arithmetic: per slice, {borrow_next, d} = {1'b0, a_slice} - {1'b0, b_slice} - borrow, taken (CHUNK+1) bits wide. borrow_next is the MSB.
- Reset (rst=0, at any time including mid-RUN or in DONE): state IDLE, idx 0, in_ready=1 from the following cycle, out_valid=0, diff=0, bout=0. Any in-flight operation is discarded.

## Timing
- Accept edge T, where in_valid && in_ready.
- RUN occupies cycles T+1 through T+NCHUNK.
- out_valid rises after edge T+NCHUNK, i.e. NCHUNK cycles after acceptance (4 for the defaults).
- out_valid holds, with diff and bout constant, until out_ready is sampled high. IDLE and in_ready=1 follow on the next cycle.
- There is no accept in the same cycle as the output handshake. Best-case throughput is one operation per NCHUNK+2 cycles.
- All outputs are registered. No combinational path from inputs to outputs.

## Configuration
- SUB_SATURATE_EN defined: when the final borrow is 1, diff is forced to 0 in DONE; bout still reports 1.
- SUB_SATURATE_EN undefined: diff is the raw modulo-2^HALF result.

## Structure
- Package seq_sub_pkg holds:
  - typedef enum for the FSM states (IDLE, RUN, DONE);
  - localparam helpers for HALF and NCHUNK;
  - an elaboration-time check that WIDTH is even and that CHUNK divides HALF.
- Sub-module sub_chunk: a purely combinational CHUNK-bit borrow subtractor with ports (a, b, bi, d, bo). Instantiated once and shared across slices through the index mux.
- All registers, the FSM and the handshake live in the top module.

## Test plan
- Basic: data_in=32'h0003_0005, bin=0 -> diff=16'h0002, bout=0, out_valid exactly 4 cycles after the accept edge.
- Underflow: data_in=32'h0001_0000, bin=0 -> diff=16'hFFFF, bout=1. With SUB_SATURATE_EN: diff=16'h0000, bout=1.
- Cross-chunk borrow: data_in=32'h0001_0100, bin=1 -> diff=16'h00FE, bout=0. Also data_in=32'h0001_1000, bin=1 -> diff=16'h0FFE, bout=0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid, diff and bout stay constant, in_ready stays 0, and a new in_valid is ignored. Release -> in_ready=1 on the next cycle, and the next word is accepted correctly.
- Reset mid-RUN: assert rst=0 at cycle 2 of RUN -> next cycle out_valid=0, diff=0, bout=0, in_ready=1. A subsequent operation gives the correct result.
- Back-to-back random: 1000 random (A, B, bin) triples with random out_ready stalls -> every result matches the reference model (A - B - bin) mod 2^16 with the borrow flag, and the result count equals the accept count.
